// File: rtl/seq101_tx.sv
// seq101_tx: serial frame transmitter, 1-0-1 preamble + MSB-first payload + idle-zero gap.
// Optional even-parity bit after the payload is enabled by defining SEQ101_TX_PARITY_EN.
module seq101_tx #(
    parameter int WIDTH = 8,
    parameter int GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    output logic             ready,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int MAXC = (WIDTH > GAP) ? ((WIDTH > 3) ? WIDTH : 3) : ((GAP > 3) ? GAP : 3);
    localparam int CW   = $clog2(MAXC);

    localparam logic [CW-1:0] PRE_MID   = CW'(1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(2);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP - 1);

`ifdef SEQ101_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_PAR  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    function automatic logic even_par(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction

    logic par_r;
    logic par_s;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DATA = 3'd2,
        S_GAP  = 3'd4
    } state_t;
`endif

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic             x_r, x_s;
    logic             busy_r, busy_s;
    logic             ready_r, ready_s;
    logic             done_r, done_s;

    // State, counter, payload and registered line outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
            shift_r <= '0;
            x_r     <= 1'b0;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
`ifdef SEQ101_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            shift_r <= shift_s;
            x_r     <= x_s;
            busy_r  <= busy_s;
            ready_r <= ready_s;
            done_r  <= done_s;
`ifdef SEQ101_TX_PARITY_EN
            par_r   <= par_s;
`endif
        end
    end

    // Next state, then the outputs that state will present (registered so they align with it).
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + 1'b1;
        shift_s = shift_r;
        x_s     = 1'b0;
        done_s  = 1'b0;
`ifdef SEQ101_TX_PARITY_EN
        par_s   = par_r;
`endif
        case (state_r)
            S_IDLE: begin
                cnt_s = '0;
                if (valid) begin
                    state_s = S_PRE;
                    shift_s = data;
`ifdef SEQ101_TX_PARITY_EN
                    par_s   = even_par(data);
`endif
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_PRE: begin
                if (cnt_r == PRE_LAST) begin
                    state_s = S_DATA;
                    cnt_s   = '0;
                end else begin
                    state_s = S_PRE;
                end
            end
            S_DATA: begin
                if (cnt_r == DATA_LAST) begin
`ifdef SEQ101_TX_PARITY_EN
                    state_s = S_PAR;
`else
                    state_s = S_GAP;
`endif
                    cnt_s   = '0;
                end else begin
                    shift_s = shift_r << 1'b1;
                end
            end
`ifdef SEQ101_TX_PARITY_EN
            S_PAR: begin
                state_s = S_GAP;
                cnt_s   = '0;
            end
`endif
            S_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_s = S_IDLE;
                    cnt_s   = '0;
                end else begin
                    state_s = S_GAP;
                end
            end
            default: begin
                state_s = S_IDLE;
                cnt_s   = '0;
            end
        endcase

        // The MSB of the shifter is always the bit due on the line next.
        case (state_s)
            S_PRE:  x_s = (cnt_s != PRE_MID);
            S_DATA: begin
                x_s = shift_s[WIDTH-1];
`ifdef SEQ101_TX_PARITY_EN
                done_s = 1'b0;
`else
                done_s = (cnt_s == DATA_LAST);
`endif
            end
`ifdef SEQ101_TX_PARITY_EN
            S_PAR: begin
                x_s    = par_s;
                done_s = 1'b1;
            end
`endif
            default: x_s = 1'b0;
        endcase
    end

    assign busy_s  = (state_s != S_IDLE);
    assign ready_s = (state_s == S_IDLE);

    assign x     = x_r;
    assign busy  = busy_r;
    assign ready = ready_r;
    assign done  = done_r;

endmodule

// File: tb/tb_seq101_tx.sv
// Self-checking bench for seq101_tx: frame-level reference model feeding a per-cycle scoreboard.
module tb_seq101_tx;

    localparam int WIDTH = 8;
    localparam int GAP   = 2;
`ifdef SEQ101_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    typedef struct packed {
        logic x;
        logic done;
    } bit_t;

    typedef struct packed {
        logic x;
        logic done;
        logic busy;
        logic ready;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             valid = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic             ready, x, busy, done;

    int   checks = 0;
    int   errors = 0;
    bit_t frame_q[$];
    exp_t exp_q[$];
    logic m_idle = 1'b1;

    seq101_tx #(.WIDTH(WIDTH), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .valid(valid), .data(data),
        .ready(ready), .x(x), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Whole frame as the line should carry it: preamble, payload MSB-first, parity, idle gap.
    task automatic load_frame(input logic [WIDTH-1:0] w);
        frame_q.delete();
        frame_q.push_back('{1'b1, 1'b0});
        frame_q.push_back('{1'b0, 1'b0});
        frame_q.push_back('{1'b1, 1'b0});
        for (int i = WIDTH - 1; i >= 0; i--)
            frame_q.push_back('{w[i], (i == 0 && P == 0)});
        if (P == 1)
            frame_q.push_back('{($countones(w) % 2 == 1), 1'b1});
        for (int i = 0; i < GAP; i++)
            frame_q.push_back('{1'b0, 1'b0});
    endtask

    task automatic model_step();
        bit_t b;
        exp_t e;
        if (!reset) begin
            frame_q.delete();
            m_idle = 1'b1;
            e = '{1'b0, 1'b0, 1'b0, 1'b1};
        end else if (m_idle && valid) begin
            load_frame(data);
            b = frame_q.pop_front();
            m_idle = 1'b0;
            e = '{b.x, b.done, 1'b1, 1'b0};
        end else if (frame_q.size() > 0) begin
            b = frame_q.pop_front();
            e = '{b.x, b.done, 1'b1, 1'b0};
        end else begin
            m_idle = 1'b1;
            e = '{1'b0, 1'b0, 1'b0, 1'b1};
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input logic r, input logic v, input logic [WIDTH-1:0] d);
        @(negedge clk);
        reset = r;
        valid = v;
        data  = d;
        @(posedge clk);
        model_step();
    endtask

    // Scoreboard monitor: pops the expectation for each cycle, away from the clock edges.
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 4;
            if (x !== e.x) begin
                errors++;
                $display("FAIL x: got %b expected %b at %0t", x, e.x, $time);
            end
            if (done !== e.done) begin
                errors++;
                $display("FAIL done: got %b expected %b at %0t", done, e.done, $time);
            end
            if (busy !== e.busy) begin
                errors++;
                $display("FAIL busy: got %b expected %b at %0t", busy, e.busy, $time);
            end
            if (ready !== e.ready) begin
                errors++;
                $display("FAIL ready: got %b expected %b at %0t", ready, e.ready, $time);
            end
        end
    end

    initial begin
        // Reset held with valid high: nothing may start.
        cyc(1'b0, 1'b1, 8'hA5);
        cyc(1'b0, 1'b1, 8'h5A);
        repeat (3) cyc(1'b1, 1'b0, 8'h00);

        // Single frames including the parity corner words.
        cyc(1'b1, 1'b1, 8'hA5);
        repeat (16) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h07);
        repeat (16) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h03);
        repeat (16) cyc(1'b1, 1'b0, 8'h00);

        // Back-to-back with valid held high the whole time.
        cyc(1'b1, 1'b1, 8'hFF);
        repeat (32) cyc(1'b1, 1'b1, 8'h00);
        repeat (4) cyc(1'b1, 1'b0, 8'h00);

        // Abort in cycle 6, then an immediate fresh frame.
        cyc(1'b1, 1'b1, 8'hC3);
        repeat (5) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 8'h96);
        repeat (16) cyc(1'b1, 1'b0, 8'h00);

        // Payload must be the word latched at accept, whatever data does afterwards.
        cyc(1'b1, 1'b1, 8'h3C);
        cyc(1'b1, 1'b0, 8'hC3);
        repeat (16) cyc(1'b1, 1'b0, 8'($urandom));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++)
            cyc(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));

        repeat (2) @(posedge clk);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq101_tx.md
# seq101_tx

Serial frame transmitter that drives the single-bit line consumed by the team's Mealy "101" sequence detector. Each accepted parallel word goes out MSB-first behind a fixed `1,0,1` preamble, so the downstream detector's `found` pulse marks frame start. A trailing run of idle zeros returns the detector to its start state before the next frame. Sits between a parallel producer and the serial link.

## Interface
- `WIDTH`, default 8: payload bits per frame (legal range 1..32).
- `GAP`, default 2: idle-zero cycles after each frame (legal range 1..15).

- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on rising edge of `clk`.
- `valid`  in  1  producer has a word on `data`.
- `data`  in  WIDTH  payload word.
- `ready`  out  1  transmitter can accept a word this cycle.
- `x`  out  1  serial line (registered); idle level 0.
- `busy`  out  1  frame in progress (preamble, payload, parity or gap).
- `done`  out  1  one-cycle pulse while the final payload/parity bit is on `x`.

## Operation
- Reset values (reset low at a rising edge): `x`=0, `ready`=1, `busy`=0, `done`=0, state IDLE, bit counter 0, shift register 0.
- Accept: rising edge with `valid`=1 and `ready`=1; `data` is latched into the shift register; later changes to `data` are ignored. `valid` while `ready`=0 is ignored (no queueing).
- States:
  - IDLE: `x`=0, `ready`=1. On accept -> PRE.
  - PRE: 3 cycles driving 1, 0, 1. -> DATA.
  - DATA: WIDTH cycles, bit WIDTH-1 first, down to bit 0. -> PAR if enabled, else GAP.
  - PAR: 1 cycle driving the parity bit (see Configuration). -> GAP.
  - GAP: GAP cycles, `x`=0. -> IDLE.
- `busy`=1 in PRE, DATA, PAR and GAP. `ready`=~`busy`.
- The bit counter is sized for max(WIDTH, GAP, 3). It is cleared on every state change. No wrap occurs inside any state.
- Reset mid-frame aborts the frame with no completion. `x`=0 and `ready`=1 on the edge following reset. The word being sent is discarded.
- Unreachable state encodings recover to IDLE on the next edge.

## Timing
- Cycle 0 is the accept edge. `x` carries preamble bit 1 in cycle 1 (the cycle after the accept edge), bit 2 in cycle 2 and bit 3 in cycle 3.
- Payload bit k (MSB = k=0) is on `x` in cycle 4+k.
- With parity, the parity bit is on `x` in cycle 4+WIDTH.
- `done`=1 exactly in the cycle of the last payload or parity bit.
- Frame length L = 3 + WIDTH + P + GAP cycles, where P is 1 with parity and 0 without.
- `ready` returns to 1 in cycle L+1. Back-to-back frames therefore start every L+1 cycles.
- The detector asserts `found` during cycle 3, on the third preamble bit.

## Configuration
- `SEQ101_TX_PARITY_EN` defined: the PAR state exists. The parity bit is the even parity of the latched word (XOR of all WIDTH bits), so the frame carries an even number of ones in payload plus parity. P=1.
- Not defined: no PAR state, no parity logic, DATA goes directly to GAP. P=0.

## Test plan
- Reset: hold `reset`=0 for 2 edges while `valid`=1 -> `x`=0, `ready`=1, `busy`=0, `done`=0 throughout, and no frame starts.
- Single frame, WIDTH=8, GAP=2, no parity, `data`=8'hA5 -> `x` sequence from cycle 1 is 1,0,1,1,0,1,0,0,1,0,1,0,0. `done` is high in cycle 11 only. `ready`=1 again in cycle 14.
- Parity build, `data`=8'h07 -> parity bit 1 in cycle 12. `data`=8'h03 -> parity bit 0. L=14.
- Back-to-back: `valid` held high with words 8'hFF then 8'h00 -> second accept at cycle 14. `valid` during `busy` causes no extra accept. Chained with the detector, `found` pulses once per frame in preamble cycle 3 (for these payloads).
- Abort: assert reset in cycle 6 of a frame -> `x`=0, `busy`=0, `ready`=1 after that edge. `done` never pulses. A new accept one cycle later sends a clean full frame.
- Data stability: change `data` in cycle 2 of a frame -> the transmitted payload equals the word latched at accept.
